// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks the destinations of instructions that have left D and are still in
// flight (stage 1 = E ... stage STAGES = W). From that record it decides
// whether the D-stage instruction has to stall, and which stage each of its
// sources can be forwarded from.
// Two more stall sources share the same Stall output:
//   - a multi-cycle multiply/divide unit (MDU) that is still busy;
//   - an eret that must wait for an in-flight EPC write.
// A saturating counter records how many cycles were spent stalled.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    input  logic [TW-1:0]    T_use_RS,
    input  logic [TW-1:0]    T_use_RT,
    input  logic [4:0]       D_A3,
    input  logic             D_RFWr,
    input  logic [TW-1:0]    D_Tnew,
    input  logic             D_MTC0_EPC,
    input  logic             D_eret,
    input  logic             D_MDU_related,
    input  logic             D_MDU_start,
    input  logic             D_MDU_div,
    input  logic             flush,
    output logic             Stall,
    output logic [2:0]       Fwd_D_RS_Sel,
    output logic [2:0]       Fwd_D_RT_Sel,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MDU_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MDU_W   = $clog2(MDU_MAX + 1);

    // Result of searching the tracked stages for one source register.
    typedef struct packed {
        logic          hit;
        logic [2:0]    idx;
        logic [TW-1:0] tnew;
    } match_t;

    // Per-stage tracking state; index k is the stage number (1 = E).
    logic [STAGES:1]         vld_q, vld_d;
    logic [STAGES:1]         wr_q, wr_d;
    logic [STAGES:1][4:0]    a3_q, a3_d;
    logic [STAGES:1][TW-1:0] tnew_q, tnew_d;

    // The EPC flag only matters while the write is still ahead of the last
    // stage, so the last stage does not keep a copy of it.
    logic [STAGES-1:1]       epc_q, epc_d;

    logic [MDU_W-1:0]        mdu_q, mdu_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    match_t rs_m, rt_m;
    logic   rs_stall, rt_stall, mdu_stall, eret_stall, epc_pending;

    // Ready-time countdown: saturates at zero.
    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? v : v - TW'(1);
    endfunction

    // Stall-cycle counter step: saturates at all-ones.
    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Return the youngest tracked producer of src.
    // $0 never matches.
    function automatic match_t find_match(
        input logic [4:0]              src,
        input logic [STAGES:1]         vld,
        input logic [STAGES:1]         wr,
        input logic [STAGES:1][4:0]    a3,
        input logic [STAGES:1][TW-1:0] tnew
    );
        match_t m;
        m = '0;
        // Walk from the oldest stage to the youngest.
        // A younger match therefore overwrites (masks) an older one.
        for (int k = STAGES; k >= 1; k--) begin
            if (vld[k] && wr[k] && (a3[k] == src) && (src != 5'd0)) begin
                m.hit  = 1'b1;
                m.idx  = 3'(k);
                m.tnew = tnew[k];
            end
        end
        return m;
    endfunction

    assign mdu_busy  = (mdu_q != '0);
    assign stall_cnt = cnt_q;

    // Hazard detection and forwarding select.
    // Purely combinational from the tracked state and the D-stage inputs.
    always_comb begin
        rs_m = find_match(D_A1, vld_q, wr_q, a3_q, tnew_q);
        rt_m = find_match(D_A2, vld_q, wr_q, a3_q, tnew_q);

        rs_stall  = rs_m.hit && (rs_m.tnew > T_use_RS);
        rt_stall  = rt_m.hit && (rt_m.tnew > T_use_RT);
        mdu_stall = D_MDU_related && mdu_busy;

        epc_pending = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            epc_pending = epc_pending | (vld_q[k] & epc_q[k]);
        end
        eret_stall = D_eret && epc_pending;

        Stall = rs_stall | rt_stall | mdu_stall | eret_stall;

        // A producer can forward only once its value is ready (tnew == 0).
        Fwd_D_RS_Sel = (rs_m.hit && (rs_m.tnew == '0)) ? rs_m.idx : 3'd0;
        Fwd_D_RT_Sel = (rt_m.hit && (rt_m.tnew == '0)) ? rt_m.idx : 3'd0;
    end

    // Next state: advance the stage record, step the MDU countdown and the
    // stall counter.
    always_comb begin
        vld_d  = vld_q;
        wr_d   = wr_q;
        a3_d   = a3_q;
        tnew_d = tnew_q;
        epc_d  = epc_q;
        mdu_d  = mdu_q;
        cnt_d  = cnt_q;

        // --- D -> stage 1: a stalled or flushed D inserts a bubble ---
        vld_d[1]  = ~Stall & ~flush;
        wr_d[1]   = D_RFWr;
        a3_d[1]   = D_A3;
        tnew_d[1] = D_Tnew;
        epc_d[1]  = D_MTC0_EPC;

        // --- stage k-1 -> stage k: the ready countdown ticks down ---
        for (int k = 2; k <= STAGES; k++) begin
            vld_d[k]  = vld_q[k-1] & ~flush;
            wr_d[k]   = wr_q[k-1];
            a3_d[k]   = a3_q[k-1];
            tnew_d[k] = dec_sat(tnew_q[k-1]);
        end
        for (int k = 2; k < STAGES; k++) begin
            epc_d[k] = epc_q[k-1];
        end

        // An MDU op starts only when it actually leaves D.
        // flush deliberately leaves the MDU countdown alone.
        if (D_MDU_start && !Stall) begin
            mdu_d = D_MDU_div ? MDU_W'(DIV_LAT) : MDU_W'(MULT_LAT);
        end else if (mdu_q != '0) begin
            mdu_d = mdu_q - MDU_W'(1);
        end

        if (Stall) begin
            cnt_d = inc_sat(cnt_q);
        end
    end

    // State registers.
    // The asynchronous reset empties the scoreboard and aborts any MDU op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            wr_q   <= '0;
            a3_q   <= '0;
            tnew_q <= '0;
            epc_q  <= '0;
            mdu_q  <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            wr_q   <= wr_d;
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
            epc_q  <= epc_d;
            mdu_q  <= mdu_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard.
// The reference model tracks in-flight instructions by the edge on which
// they left D. Each one's stage and remaining ready time are derived from
// its age.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int STAGES   = 3;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       D_A1, D_A2, D_A3;
    logic [TW-1:0]    T_use_RS, T_use_RT, D_Tnew;
    logic             D_RFWr, D_MTC0_EPC, D_eret;
    logic             D_MDU_related, D_MDU_start, D_MDU_div, flush;
    logic             Stall, mdu_busy;
    logic [2:0]       Fwd_D_RS_Sel, Fwd_D_RT_Sel;
    logic [CNT_W-1:0] stall_cnt;

    hazard_scoreboard #(
        .STAGES(STAGES), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .T_use_RS(T_use_RS), .T_use_RT(T_use_RT),
        .D_A3(D_A3), .D_RFWr(D_RFWr), .D_Tnew(D_Tnew), .D_MTC0_EPC(D_MTC0_EPC),
        .D_eret(D_eret), .D_MDU_related(D_MDU_related), .D_MDU_start(D_MDU_start),
        .D_MDU_div(D_MDU_div), .flush(flush),
        .Stall(Stall), .Fwd_D_RS_Sel(Fwd_D_RS_Sel), .Fwd_D_RT_Sel(Fwd_D_RT_Sel),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    a1, a2;
        logic [TW-1:0] tu_rs, tu_rt;
        logic [4:0]    a3;
        logic          wr;
        logic [TW-1:0] tnew;
        logic          epc, eret, mrel, mstart, mdiv, flush;
    } stim_t;

    typedef struct packed {
        logic             stall;
        logic [2:0]       frs, frt;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        int e;     // edge on which it left D
        int a3;
        bit wr;
        int tnew;  // ready time on entry to stage 1
        bit epc;
    } instr_t;

    exp_t   exp_q[$];
    instr_t pipe[$];
    int     n_edges  = 0;
    int     mdu_e    = 0;
    int     mdu_lat  = 0;
    longint m_cnt    = 0;
    int     n_cmp    = 0;
    int     n_bad    = 0;

    task automatic apply(input stim_t s);
        D_A1 = s.a1; D_A2 = s.a2; T_use_RS = s.tu_rs; T_use_RT = s.tu_rt;
        D_A3 = s.a3; D_RFWr = s.wr; D_Tnew = s.tnew; D_MTC0_EPC = s.epc;
        D_eret = s.eret; D_MDU_related = s.mrel; D_MDU_start = s.mstart;
        D_MDU_div = s.mdiv; flush = s.flush;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.a1     = 5'($urandom_range(0, 3));
        s.a2     = 5'($urandom_range(0, 3));
        s.a3     = 5'($urandom_range(0, 3));
        s.tu_rs  = TW'($urandom_range(0, 3));
        s.tu_rt  = TW'($urandom_range(0, 3));
        s.tnew   = TW'($urandom_range(0, 3));
        s.wr     = ($urandom_range(0, 9) < 8);
        s.epc    = ($urandom_range(0, 9) == 0);
        s.eret   = ($urandom_range(0, 6) == 0);
        s.mrel   = ($urandom_range(0, 4) == 0);
        s.mstart = ($urandom_range(0, 9) == 0);
        s.mdiv   = ($urandom_range(0, 1) == 1);
        s.flush  = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    // Youngest in-flight writer of s decides stall and forwarding.
    function automatic void lookup(input int s, input int tuse, output bit st, output int fwd);
        int stage, tn;
        st  = 0;
        fwd = 0;
        if (s == 0) return;
        for (int i = pipe.size() - 1; i >= 0; i--) begin
            stage = n_edges - pipe[i].e + 1;
            if (stage >= 1 && stage <= STAGES && pipe[i].wr && pipe[i].a3 == s) begin
                tn  = pipe[i].tnew - (stage - 1);
                if (tn < 0) tn = 0;
                st  = (tn > tuse);
                fwd = (tn == 0) ? stage : 0;
                return;
            end
        end
    endfunction

    function automatic exp_t model_eval(input stim_t s);
        exp_t r;
        bit   srs, srt, busy, er;
        int   frs, frt, stage;
        lookup(int'(s.a1), int'(s.tu_rs), srs, frs);
        lookup(int'(s.a2), int'(s.tu_rt), srt, frt);
        busy = (mdu_lat > 0) && ((n_edges - mdu_e) < mdu_lat);
        er = 0;
        foreach (pipe[i]) begin
            stage = n_edges - pipe[i].e + 1;
            if (pipe[i].epc && stage >= 1 && stage <= STAGES - 1) er = 1;
        end
        r.stall = srs | srt | (s.mrel & busy) | (s.eret & er);
        r.frs   = 3'(frs);
        r.frt   = 3'(frt);
        r.busy  = busy;
        r.cnt   = CNT_W'(m_cnt);
        return r;
    endfunction

    function automatic void model_step(input stim_t s, input bit stall);
        instr_t it;
        if (s.flush) begin
            pipe.delete();
        end else if (!stall) begin
            it.e = n_edges + 1; it.a3 = int'(s.a3); it.wr = s.wr;
            it.tnew = int'(s.tnew); it.epc = s.epc;
            pipe.push_back(it);
        end
        if (s.mstart && !stall) begin
            mdu_e   = n_edges + 1;
            mdu_lat = s.mdiv ? DIV_LAT : MULT_LAT;
        end
        n_edges++;
        if (stall && m_cnt < ((longint'(1) << CNT_W) - 1)) m_cnt++;
        while (pipe.size() > 0 && (n_edges - pipe[0].e + 1) > STAGES) void'(pipe.pop_front());
    endfunction

    function automatic void model_clear();
        pipe.delete();
        mdu_lat = 0;
        m_cnt   = 0;
    endfunction

    // One D-stage cycle: drive inputs, queue the expected response, advance the model.
    task automatic drive_cycle(input stim_t s);
        exp_t x;
        @(posedge clk);
        #2;
        apply(s);
        x = model_eval(s);
        exp_q.push_back(x);
        model_step(s, x.stall);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_stall"}, int'(Stall), 0);
        check({tag, "_fwd_rs"}, int'(Fwd_D_RS_Sel), 0);
        check({tag, "_fwd_rt"}, int'(Fwd_D_RT_Sel), 0);
        check({tag, "_busy"}, int'(mdu_busy), 0);
        check({tag, "_cnt"}, int'(stall_cnt), 0);
    endtask

    // Called 3ns after an edge. Reset is pulsed between clock edges and its
    // effect is checked before the next edge.
    task automatic reset_mid();
        #3 reset = 1'b1;
        #1 check_cleared("rst_mid");
        model_clear();
        apply('0);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0);
    endtask

    // Monitor: compares every queued expectation against the DUT outputs mid-cycle.
    initial begin : monitor
        exp_t x, got;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                got = {Stall, Fwd_D_RS_Sel, Fwd_D_RT_Sel, mdu_busy, stall_cnt};
                n_cmp++;
                if (got !== x) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got stall=%0b rs=%0d rt=%0d busy=%0b cnt=%0d, expected stall=%0b rs=%0d rt=%0d busy=%0b cnt=%0d",
                             $time, got.stall, got.frs, got.frt, got.busy, got.cnt,
                             x.stall, x.frs, x.frt, x.busy, x.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        stim_t s;
        longint base;

        // Reset held: outputs stay cleared whatever D presents.
        reset = 1'b1;
        apply(rand_stim());
        #1;
        for (int i = 0; i < 4; i++) begin
            apply(rand_stim());
            #3 check_cleared("rst_hold");
        end
        apply('0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use: producer ready 2 cycles after entering E, consumer needs it in 1.
        s = '0; s.a3 = 5'd2; s.wr = 1'b1; s.tnew = 2'd2;
        drive_cycle(s); #1 check("lu_issue_stall", int'(Stall), 0);
        s = '0; s.a1 = 5'd2; s.tu_rs = 2'd1;
        drive_cycle(s); #1 check("lu_stall", int'(Stall), 1);
        drive_cycle(s); #1 check("lu_release", int'(Stall), 0);
        check("lu_fwd_m", int'(Fwd_D_RS_Sel), 0);
        drive_cycle(s); #1 check("lu_fwd_w", int'(Fwd_D_RS_Sel), 3);
        idle(STAGES + 1);

        // ALU result feeding a branch compare.
        s = '0; s.a3 = 5'd5; s.wr = 1'b1; s.tnew = 2'd1;
        drive_cycle(s);
        s = '0; s.a2 = 5'd5; s.tu_rt = 2'd0;
        drive_cycle(s); #1 check("alu_br_stall", int'(Stall), 1);
        drive_cycle(s); #1 check("alu_br_release", int'(Stall), 0);
        check("alu_br_fwd", int'(Fwd_D_RT_Sel), 2);
        idle(STAGES + 1);

        // $0 never creates a hazard.
        s = '0; s.a3 = 5'd0; s.wr = 1'b1; s.tnew = 2'd2;
        drive_cycle(s);
        s = '0; s.a1 = 5'd0; s.tu_rs = 2'd0;
        drive_cycle(s); #1 check("zero_stall", int'(Stall), 0);
        check("zero_fwd", int'(Fwd_D_RS_Sel), 0);
        idle(STAGES + 1);

        // Multiply: 5 stalled cycles.
        s = '0; s.mstart = 1'b1;
        drive_cycle(s); #1 check("mul_idle_busy", int'(mdu_busy), 0);
        base = m_cnt;
        s = '0; s.mrel = 1'b1;
        for (int i = 0; i < MULT_LAT; i++) begin
            drive_cycle(s); #1 check("mul_stall", int'(Stall), 1);
            check("mul_busy", int'(mdu_busy), 1);
        end
        drive_cycle(s); #1 check("mul_release", int'(Stall), 0);
        check("mul_busy_end", int'(mdu_busy), 0);
        check("mul_cnt", int'(stall_cnt), int'(base + MULT_LAT));

        // Divide: 10 stalled cycles.
        s = '0; s.mstart = 1'b1; s.mdiv = 1'b1;
        drive_cycle(s);
        base = m_cnt;
        s = '0; s.mrel = 1'b1;
        for (int i = 0; i < DIV_LAT; i++) begin
            drive_cycle(s); #1 check("div_stall", int'(Stall), 1);
        end
        drive_cycle(s); #1 check("div_release", int'(Stall), 0);
        check("div_busy_end", int'(mdu_busy), 0);
        check("div_cnt", int'(stall_cnt), int'(base + DIV_LAT));
        idle(2);

        // eret waits while the EPC write is in stages 1..STAGES-1.
        s = '0; s.epc = 1'b1;
        drive_cycle(s);
        s = '0; s.eret = 1'b1;
        for (int i = 0; i < STAGES - 1; i++) begin
            drive_cycle(s); #1 check("eret_stall", int'(Stall), 1);
        end
        drive_cycle(s); #1 check("eret_release", int'(Stall), 0);
        idle(STAGES + 1);

        // A flush in the first stall cycle ends the eret stall.
        s = '0; s.epc = 1'b1;
        drive_cycle(s);
        s = '0; s.eret = 1'b1; s.flush = 1'b1;
        drive_cycle(s); #1 check("flush_stall", int'(Stall), 1);
        s.flush = 1'b0;
        drive_cycle(s); #1 check("flush_release", int'(Stall), 0);
        idle(STAGES + 1);

        // Reset in the middle of an MDU stall.
        s = '0; s.mstart = 1'b1;
        drive_cycle(s);
        s = '0; s.mrel = 1'b1;
        drive_cycle(s); #1 check("rst_op_stall", int'(Stall), 1);
        drive_cycle(s); #1 check("rst_op_busy", int'(mdu_busy), 1);
        reset_mid();
        idle(2);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(rand_stim());
            if ($urandom_range(0, 199) == 0) begin
                #1 reset_mid();
            end
        end

        repeat (3) @(posedge clk);
        #5 check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of tracked stages after D (stage 1 = E, stage STAGES = W), range 2..7.
REQ-002 SHALL have parameter TW, default 2, width of T_use/Tnew fields.
REQ-003 SHALL have parameter MULT_LAT, default 5, MDU busy cycles for mult-class ops.
REQ-004 SHALL have parameter DIV_LAT, default 10, MDU busy cycles for div-class ops.
REQ-005 SHALL have parameter CNT_W, default 32, stall counter width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 D_A1, D_A2  in  5  D-stage rs/rt source register numbers.
REQ-009 T_use_RS, T_use_RT  in  TW  cycles until D needs rs/rt.
REQ-010 D_A3, D_RFWr, D_Tnew  in  5/1/TW  D destination, write enable, Tnew on entry to E.
REQ-011 D_MTC0_EPC  in  1  D instruction writes CP0 register 14 (EPC).
REQ-012 D_eret  in  1  D instruction is eret.
REQ-013 D_MDU_related, D_MDU_start, D_MDU_div  in  1/1/1  D uses HI/LO or MDU; D starts MDU op; started op is div-class.
REQ-014 flush  in  1  clear all tracked stages at next edge.
REQ-015 Stall  out  1  hold F/D, bubble into E.
REQ-016 Fwd_D_RS_Sel, Fwd_D_RT_Sel  out  3  forwarding source stage index, 0 = register file.
REQ-017 mdu_busy  out  1  MDU counter nonzero.
REQ-018 stall_cnt  out  CNT_W  stalled-cycle count.

Function
REQ-019 SHALL hold STAGES entries {valid, a3, wr, tnew, epc}; each edge, entry k+1 takes entry k with tnew decremented, saturating at 0.
REQ-020 Entry 1 SHALL load {1, D_A3, D_RFWr, D_Tnew, D_MTC0_EPC} when Stall=0 and flush=0; otherwise a bubble (valid=0).
REQ-021 flush=1 SHALL make every entry invalid at next edge; flush has priority over shifting and Stall.
REQ-022 Per source s (rs or rt): match k = smallest k with valid, wr, a3==s, s!=0; younger match masks older.
REQ-023 Source stall SHALL be 1 iff a match exists and tnew_k > T_use_s.
REQ-024 Fwd_D_*_Sel SHALL be k iff the match has tnew_k==0; else 0; always 0 when s==0.
REQ-025 MDU counter SHALL load DIV_LAT (D_MDU_div=1) or MULT_LAT when D_MDU_start=1 and Stall=0; else decrement to 0; unaffected by flush.
REQ-026 mdu_busy SHALL equal (counter != 0); MDU stall = D_MDU_related & mdu_busy.
REQ-027 eret stall SHALL be D_eret & any valid entry k < STAGES with epc=1.
REQ-028 Stall SHALL be OR of rs stall, rt stall, MDU stall, eret stall; purely combinational from state and inputs, zero added latency.
REQ-029 stall_cnt SHALL increment on each edge with Stall=1, saturating at all-ones.

Reset
REQ-030 reset=1 SHALL immediately clear all entries, MDU counter and stall_cnt to 0.
REQ-031 With state cleared, Stall, Fwd_D_RS_Sel, Fwd_D_RT_Sel, mdu_busy SHALL be 0 for any input values.
REQ-032 reset asserted mid-stall or mid-MDU-op SHALL abort it; first edge after release behaves as from empty state.

Verification
REQ-033 Load-use: issue D_A3=2,D_RFWr=1,D_Tnew=2; next cycle D_A1=2,T_use_RS=1 -> Stall=1 exactly 1 cycle, then Stall=0, Fwd_D_RS_Sel=0 with match in M (tnew 1 <= 1); cycle after, Fwd_D_RS_Sel=3.
REQ-034 ALU-branch: issue D_A3=5,Tnew=1; next D_A2=5,T_use_RT=0 -> Stall=1 1 cycle, then Fwd_D_RT_Sel=2.
REQ-035 $0: issue D_A3=0,Tnew=2; next D_A1=0,T_use_RS=0 -> Stall=0, Fwd_D_RS_Sel=0.
REQ-036 MDU: D_MDU_start=1,D_MDU_div=0 issued; next cycle D_MDU_related=1 held -> Stall=1 for 5 cycles, mdu_busy falls with it; with D_MDU_div=1 -> 10 cycles; stall_cnt +5 / +10.
REQ-037 eret/flush: issue D_MTC0_EPC=1; next D_eret=1 -> Stall=1 while epc entry in stages 1..STAGES-1 (2 cycles at STAGES=3); pulsing flush in first stall cycle -> Stall=0 next cycle.
REQ-038 Reset mid-op: assert reset during REQ-036 stall -> Stall, mdu_busy, stall_cnt 0 without waiting for clk.
